// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit SPI master among NUM_REQ clients.
// Optional RUN-state timeout abort is compiled in with macro SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [31:0]            rsp_data,
   output logic                   err,
   output logic                   busy,
   output logic                   m_rst_n,
   output logic [31:0]            m_send_data,
   input  logic                   m_complete,
   input  logic [31:0]            m_recv_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [31:0]          rsp_q, rsp_d;
   logic [31:0]          send_q, send_d;
   logic                 mrst_q, mrst_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 finish;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
   logic [TO_W-1:0]      to_q, to_d;
   logic                 err_q, err_d;
`endif

   // Candidate order: rot_idx[k] is the client k places after the priority pointer.
   logic [IDX_W-1:0]     rot_idx [NUM_REQ];
   logic [31:0]          slice   [NUM_REQ];
   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                          : IDX_W'(sum);
      assign slice[gi]    = req_data[32*gi +: 32];
   end

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[rot_idx[k]]) begin
            pick_valid = 1'b1;
            pick_idx   = rot_idx[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      rsp_d   = rsp_q;
      send_d  = send_q;
      mrst_d  = mrst_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      finish  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_d    = '0;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            mrst_d = 1'b0;
            if (pick_valid) begin
               state_d = S_LOAD;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               win_d   = pick_idx;
               send_d  = slice[pick_idx];
               cnt_d   = 8'd0;
            end
         end
         S_LOAD: begin
            if (cnt_q == 8'd1) begin
               state_d = S_RUN;
               mrst_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RUN: begin
`ifdef SPI_ARB_TIMEOUT_EN
            to_d = (!m_complete && to_q != TO_MAX) ? to_q + TO_W'(1) : to_q;
`endif
            if (m_complete) begin
               finish = 1'b1;
               rsp_d  = m_recv_data;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (to_q == TO_MAX) begin
               finish = 1'b1;
               rsp_d  = 32'hDEAD_BEEF;
               err_d  = 1'b1;
            end
`endif
         end
         S_GAP: begin
            if (cnt_q >= 8'(GAP_CYCLES - 1)) state_d = S_IDLE;
            else                              cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // With a zero gap the done cycle itself is already IDLE, giving a 1-cycle turnaround.
      if (finish) begin
         done_d  = gnt_q;
         gnt_d   = '0;
         mrst_d  = 1'b0;
         cnt_d   = 8'd0;
         ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
         state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         rsp_q   <= '0;
         send_q  <= '0;
         mrst_q  <= 1'b0;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         to_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         rsp_q   <= rsp_d;
         send_q  <= send_d;
         mrst_q  <= mrst_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
         to_q    <= to_d;
         err_q   <= err_d;
`endif
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign rsp_data    = rsp_q;
   assign m_send_data = send_q;
   assign m_rst_n     = mrst_q;
   assign busy        = (state_q != S_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
   assign err         = err_q;
`else
   assign err         = 1'b0;
`endif

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one 32-bit SPI master among `NUM_REQ` requesters. It sits between the requesting client blocks and the SPI master. For each frame it drives the master's active-low reset low to load the send word, then releases it to run the frame. It waits for the master's completion flag, returns the received word to the winning requester, and enforces a chip-select idle gap before the next frame.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 2: idle cycles between frames, master held in reset so CS is high; 0..255.
- `TIMEOUT_CYCLES`, default 1024: RUN-state cycle limit. Used only with `SPI_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req` in `NUM_REQ`: request per client. Held high until that client's `done`.
- `req_data` in `32*NUM_REQ`: send words. Client i uses bits `[32*i+31:32*i]`; the slice must be stable while `req[i]` is high.
- `gnt` out `NUM_REQ`: one-hot grant, high from grant until `done`.
- `done` out `NUM_REQ`: one-cycle completion pulse to the granted client.
- `rsp_data` out 32: received word, valid in the `done` cycle, held until the next `done`.
- `err` out 1: one-cycle pulse, coincident with `done`, on timeout abort.
- `busy` out 1: high in any state other than IDLE.
- `m_rst_n` out 1: drives the master's active-low reset.
- `m_send_data` out 32: drives the master's send word.
- `m_complete` in 1: master's completion flag.
- `m_recv_data` in 32: master's received word.

## Operation
- **Reset values:** `gnt`=0, `done`=0, `err`=0, `rsp_data`=0, `m_send_data`=0, `m_rst_n`=0, `busy`=0, state=IDLE, priority pointer=0, counters=0.
- **States:** IDLE, LOAD, RUN, GAP.
- **IDLE:** `m_rst_n`=0.
  - If any `req` is high, pick the first requester set at or after the priority pointer, searching upward and wrapping modulo `NUM_REQ`.
  - Next edge: set `gnt` one-hot, latch that client's slice into `m_send_data`, state<=LOAD.
- **LOAD:** `m_rst_n`=0 for exactly 2 cycles so the master loads `m_send_data`. Then state<=RUN.
- **RUN:** `m_rst_n`=1 and the master runs the frame.
  - When `m_complete` is sampled high, next edge: `rsp_data`<=`m_recv_data`, `done`<=`gnt`, `gnt`<=0, `m_rst_n`<=0, priority pointer<=(winner+1) mod `NUM_REQ`, state<=GAP.
- **GAP:** `m_rst_n`=0 for `GAP_CYCLES` cycles, then IDLE.
  - With `GAP_CYCLES`=0, go directly to IDLE on the edge after `done`.
- **Request sampling:**
  - `req` is sampled only in IDLE.
  - A `req` that drops while granted does not abort the frame. The frame completes and `done` still pulses.
  - New requests arriving during LOAD/RUN/GAP wait.
- **Simultaneous requests:** the round-robin pointer decides. A client re-requesting in the cycle after its `done` has lowest priority.
- **Reset mid-operation:** all state returns to reset values on the next edge. `m_rst_n` goes low, so any in-flight frame is abandoned and no `done` is issued.

## Timing
- Grant latency: `req` high in IDLE → `gnt` high 1 cycle later.
- Master reset release: `gnt` → `m_rst_n` high 2 cycles later.
- Completion: `m_complete` high → `done`, `rsp_data` on the next edge (1-cycle latency).
- Back-to-back turnaround: `done` → next `gnt` after `GAP_CYCLES`+1 cycles.
- At most one `gnt` and one `done` bit are high in any cycle.
- Counters: GAP counter 8 bits. Timeout counter wide enough for `TIMEOUT_CYCLES`; it saturates and never wraps.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - In RUN, count cycles with `m_complete` low.
  - At `TIMEOUT_CYCLES`, abort with the completion behaviour, except `rsp_data`<=32'hDEAD_BEEF and `err` pulses with `done`.
  - The pointer advances and state<=GAP.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No timeout counter; RUN waits indefinitely.
  - `err` is tied to 0.

## Test plan
- **Single request:** `req`=4'b0100, slice 2 = 32'hA5A5_0F0F, master model loopback. Required: `gnt`=4'b0100 one cycle later; `m_rst_n` low 2 cycles; `done`=4'b0100 with `rsp_data`=32'hA5A5_0F0F.
- **Simultaneous requests:** all four `req` high from reset and held. Required: completions in order 0,1,2,3; `GAP_CYCLES`+1 cycles from each `done` to the next `gnt`.
- **Fairness:** clients 0 and 3 request continuously. Required: grants alternate 0,3,0,3 over 8 frames.
- **Reset mid-frame:** assert `rst` in RUN midway through a frame. Required: next cycle `gnt`=0, `done`=0, `m_rst_n`=0, `busy`=0. A later request completes normally, with the pointer back at 0.
- **Timeout:** with `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, and the master model never completing. Required: `done` and `err` pulse 17 cycles after RUN entry, `rsp_data`=32'hDEAD_BEEF. Without the macro: no `done` after 2000 cycles, `err` stays 0.
- **Zero gap:** `GAP_CYCLES`=0. Required: the next `gnt` comes exactly 1 cycle after `done`.
